// File: rtl/tx_ctrl_pkg.sv
// Shared definitions for the transmit-side sequencer: state encoding and block size.
package tx_ctrl_pkg;

  typedef logic [3:0] tx_state_t;

  localparam tx_state_t ST_IDLE     = 4'd0;
  localparam tx_state_t ST_ENCRYPT  = 4'd1;
  localparam tx_state_t ST_LOAD     = 4'd2;
  localparam tx_state_t ST_WAIT_RDY = 4'd3;
  localparam tx_state_t ST_XMIT     = 4'd4;
  localparam tx_state_t ST_WAIT_TX  = 4'd5;
  localparam tx_state_t ST_NEXT     = 4'd6;
  localparam tx_state_t ST_GAP      = 4'd7;
  localparam tx_state_t ST_FINISH   = 4'd8;
  localparam tx_state_t ST_ERROR    = 4'd9;

  // Ciphertext bytes per block; the CRC byte follows these.
  localparam int TX_DATA_BYTES = 16;

endpackage

// File: rtl/ctrl_cycle_counter.sv
// Up-counter with synchronous clear and a terminal-count compare.
// Shared between the encryption timeout and the inter-byte gap timing.
module ctrl_cycle_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  // Clear wins over increment so a new timing window always starts at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + 1'b1;
  end

  assign tc = (count == term);

endmodule

// File: rtl/controller_tx.sv
// Transmit sequencer: encrypt, load PISO, send DATA_BYTES ciphertext bytes
// plus one CRC byte through the UART, then pulse block_done.
module controller_tx
  import tx_ctrl_pkg::*;
#(
  parameter int DATA_BYTES  = TX_DATA_BYTES,
  parameter int GAP_CYCLES  = 2,
  parameter int ENC_TIMEOUT = 64,
  parameter int CW          = $clog2(DATA_BYTES + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          enc_done,
  input  logic          tx_busy,
  input  logic          tx_done,
  output logic          EnEnc,
  output logic          Ld,
  output logic          Shift,
  output logic          crc_clear,
  output logic          crc_en,
  output logic          sel_crc,
  output logic          tx_start,
  output logic          busy,
  output logic          block_done,
  output logic          err,
  output logic [CW-1:0] byte_cnt
);

  // The shared counter only ever needs to reach the larger terminal value minus one.
  localparam int CNT_MAX = (ENC_TIMEOUT > GAP_CYCLES) ? ENC_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] ENC_TERM = CNT_W'(ENC_TIMEOUT > 0 ? ENC_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0]    LAST_CNT = CW'(DATA_BYTES + 1);
  localparam logic [CW-1:0]    CRC_IDX  = CW'(DATA_BYTES);

  tx_state_t        state, state_next;
  logic [CW-1:0]    byte_cnt_inc;
  logic             cnt_clear, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt_term;

  assign byte_cnt_inc = byte_cnt + 1'b1;

  // Restart the counter when a timed window (encrypt wait or gap) is about to begin.
  assign cnt_clear = ((state == ST_IDLE) && start) || (state == ST_NEXT);
  assign cnt_inc   = (state == ST_ENCRYPT) || (state == ST_GAP);
  assign cnt_term  = (state == ST_GAP) ? GAP_TERM : ENC_TERM;

  ctrl_cycle_counter #(.W(CNT_W)) u_cycle_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .term  (cnt_term),
    .tc    (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Byte counter: cleared at block start and at load, bumped once per finished byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               byte_cnt <= '0;
    else if ((state == ST_IDLE) && start)     byte_cnt <= '0;
    else if (state == ST_LOAD)                byte_cnt <= '0;
    else if ((state == ST_WAIT_TX) && tx_done) byte_cnt <= byte_cnt_inc;
  end

  // Next-state logic; enc_done beats the timeout and tx_done is honoured regardless of tx_busy.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start) state_next = ST_ENCRYPT;
      ST_ENCRYPT: begin
        if (enc_done)                          state_next = ST_LOAD;
        else if ((ENC_TIMEOUT != 0) && cnt_tc) state_next = ST_ERROR;
      end
      ST_LOAD:     state_next = ST_WAIT_RDY;
      ST_WAIT_RDY: if (!tx_busy) state_next = ST_XMIT;
      ST_XMIT:     state_next = ST_WAIT_TX;
      ST_WAIT_TX:  if (tx_done) state_next = (byte_cnt_inc == LAST_CNT) ? ST_FINISH : ST_NEXT;
      ST_NEXT:     state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_WAIT_RDY;
      ST_GAP:      if (cnt_tc) state_next = ST_WAIT_RDY;
      ST_FINISH:   state_next = ST_IDLE;
      ST_ERROR:    state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Moore output decode from the registered state and byte count.
  always_comb begin
    EnEnc      = 1'b0;
    Ld         = 1'b0;
    Shift      = 1'b0;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;
    sel_crc    = 1'b0;
    tx_start   = 1'b0;
    block_done = 1'b0;
    err        = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_ENCRYPT: EnEnc = 1'b1;
      ST_LOAD: begin
        Ld        = 1'b1;
        crc_clear = 1'b1;
        EnEnc     = 1'b1;
      end
      ST_WAIT_RDY: sel_crc = (byte_cnt == CRC_IDX);
      ST_XMIT: begin
        tx_start = 1'b1;
        crc_en   = (byte_cnt < CRC_IDX);
        sel_crc  = (byte_cnt == CRC_IDX);
      end
      ST_WAIT_TX: sel_crc = (byte_cnt == CRC_IDX);
      ST_NEXT:    Shift = (byte_cnt < CRC_IDX);
      ST_FINISH:  block_done = 1'b1;
      ST_ERROR:   err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controller_tx.sv
// Randomized bench for controller_tx: two instances (default timing, and
// zero-gap / no-timeout) driven by a UART model and checked against an
// event-level reference of the block protocol.
module tb_controller_tx;

  localparam int DB    = 16;
  localparam int GAP_A = 2;
  localparam int TO_A  = 64;
  localparam int GAP_B = 0;
  localparam int TO_B  = 0;
  localparam int P_IDLE = 0, P_ENC = 1, P_RUN = 2, P_HOLD = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] start, enc_done, tx_busy, tx_done;
  logic [1:0] EnEnc, Ld, Shift, crc_clear, crc_en, sel_crc, tx_start, busy, block_done, err;
  logic [4:0] byte_cnt [2];

  int n_compared = 0;
  int n_mismatched = 0;
  int cyc = 0;

  // reference model state, one entry per instance
  int ph[2], s_tag[2], exp_ld_tag[2], exp_tx_tag[2], exp_err_tag[2], exp_done_tag[2];
  int ready_from[2], idx[2];
  bit wait_ready[2];
  // per-block event counts from the DUT outputs
  int tx_cnt[2], crc_cnt[2], shift_cnt[2], ld_cnt[2], clr_cnt[2];
  // UART model
  int rem[2], hold[2], fixed_len[2];

  controller_tx #(.DATA_BYTES(DB), .GAP_CYCLES(GAP_A), .ENC_TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .enc_done(enc_done[0]),
    .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .EnEnc(EnEnc[0]), .Ld(Ld[0]),
    .Shift(Shift[0]), .crc_clear(crc_clear[0]), .crc_en(crc_en[0]), .sel_crc(sel_crc[0]),
    .tx_start(tx_start[0]), .busy(busy[0]), .block_done(block_done[0]), .err(err[0]),
    .byte_cnt(byte_cnt[0])
  );

  controller_tx #(.DATA_BYTES(DB), .GAP_CYCLES(GAP_B), .ENC_TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .enc_done(enc_done[1]),
    .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .EnEnc(EnEnc[1]), .Ld(Ld[1]),
    .Shift(Shift[1]), .crc_clear(crc_clear[1]), .crc_en(crc_en[1]), .sel_crc(sel_crc[1]),
    .tx_start(tx_start[1]), .busy(busy[1]), .block_done(block_done[1]), .err(err[1]),
    .byte_cnt(byte_cnt[1])
  );

  always #5 clk = ~clk;

  function automatic int gap_of(int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic int to_of(int i);
    return (i == 0) ? TO_A : TO_B;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, actual, expected);
    end
  endtask

  task automatic checkAllZero(input int i, input string tag);
    int vec;
    vec = {22'd0, EnEnc[i], Ld[i], Shift[i], crc_clear[i], crc_en[i], sel_crc[i],
           tx_start[i], busy[i], block_done[i], err[i]};
    checkOutput({tag, "_outs"}, vec, 0);
    checkOutput({tag, "_byte_cnt"}, int'(byte_cnt[i]), 0);
  endtask

  // Reference model: consumes the inputs each edge and predicts the tag
  // (edge number) at which Ld, tx_start, err and block_done must appear.
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        ph[i] = P_IDLE; exp_ld_tag[i] = -1; exp_tx_tag[i] = -1;
        exp_err_tag[i] = -1; exp_done_tag[i] = -1; s_tag[i] = -1;
        wait_ready[i] = 0; idx[i] = 0;
      end else begin
        case (ph[i])
          P_IDLE: if (start[i]) begin
            ph[i] = P_ENC; s_tag[i] = cyc; idx[i] = 0;
            tx_cnt[i] = 0; crc_cnt[i] = 0; shift_cnt[i] = 0; ld_cnt[i] = 0; clr_cnt[i] = 0;
          end
          P_ENC: begin
            if (enc_done[i]) begin
              ph[i] = P_RUN; exp_ld_tag[i] = cyc;
              wait_ready[i] = 1; ready_from[i] = cyc + 2;
            end else if (to_of(i) != 0 && cyc == s_tag[i] + to_of(i)) begin
              exp_err_tag[i] = cyc; ph[i] = P_HOLD;
            end
          end
          P_RUN: begin
            if (wait_ready[i]) begin
              if (cyc >= ready_from[i] && !tx_busy[i]) begin
                exp_tx_tag[i] = cyc; wait_ready[i] = 0;
              end
            end else if (tx_done[i] && cyc >= exp_tx_tag[i] + 2) begin
              idx[i]++;
              if (idx[i] == DB + 1) begin
                exp_done_tag[i] = cyc; ph[i] = P_HOLD;
              end else begin
                wait_ready[i] = 1; ready_from[i] = cyc + gap_of(i) + 2;
              end
            end
          end
          default: ph[i] = P_IDLE;
        endcase
      end
    end
  end

  // Monitor compares outputs against the model, then the UART model reacts.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        if (cyc == s_tag[i]) begin
          checkOutput("enc_en_rise", int'(EnEnc[i]), 1);
          checkOutput("busy_rise", int'(busy[i]), 1);
        end
        if (Ld[i] || cyc == exp_ld_tag[i]) begin
          checkOutput("ld", int'(Ld[i]), int'(cyc == exp_ld_tag[i]));
          checkOutput("crc_clear", int'(crc_clear[i]), int'(cyc == exp_ld_tag[i]));
          checkOutput("ld_enc_en", int'(EnEnc[i]), 1);
        end
        if (tx_start[i] || cyc == exp_tx_tag[i]) begin
          checkOutput("tx_start", int'(tx_start[i]), int'(cyc == exp_tx_tag[i]));
          if (tx_start[i]) begin
            checkOutput("xmit_byte_cnt", int'(byte_cnt[i]), idx[i]);
            checkOutput("xmit_crc_en", int'(crc_en[i]), int'(idx[i] < DB));
            checkOutput("xmit_sel_crc", int'(sel_crc[i]), int'(idx[i] == DB));
          end
        end
        if (sel_crc[i]) checkOutput("sel_crc_idx", idx[i], DB);
        if (err[i] || cyc == exp_err_tag[i])
          checkOutput("err", int'(err[i]), int'(cyc == exp_err_tag[i]));
        if (block_done[i] || cyc == exp_done_tag[i]) begin
          checkOutput("block_done", int'(block_done[i]), int'(cyc == exp_done_tag[i]));
          if (block_done[i]) begin
            checkOutput("n_tx_start", tx_cnt[i] + int'(tx_start[i]), DB + 1);
            checkOutput("n_crc_en", crc_cnt[i], DB);
            checkOutput("n_shift", shift_cnt[i], DB - 1);
            checkOutput("n_ld", ld_cnt[i], 1);
            checkOutput("n_crc_clear", clr_cnt[i], 1);
            checkOutput("done_byte_cnt", int'(byte_cnt[i]), DB + 1);
          end
        end
        tx_cnt[i] += int'(tx_start[i]);
        crc_cnt[i] += int'(crc_en[i]);
        shift_cnt[i] += int'(Shift[i]);
        ld_cnt[i] += int'(Ld[i]);
        clr_cnt[i] += int'(crc_clear[i]);
      end
      // UART transmitter model
      if (!reset) begin
        rem[i] = 0; hold[i] = 0;
        tx_busy[i] = 1'($urandom_range(1, 0));
        tx_done[i] = 1'($urandom_range(1, 0));
      end else begin
        tx_done[i] = 1'b0;
        if (tx_start[i]) begin
          rem[i] = (fixed_len[i] > 0) ? fixed_len[i] : int'($urandom_range(20, 3));
          tx_busy[i] = 1'b1;
        end else if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) begin
            tx_done[i] = 1'b1;
            hold[i] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(50, 1)) : 0;
            tx_busy[i] = (hold[i] > 0) || ($urandom_range(1, 0) == 1);
          end
        end else if (hold[i] > 0) begin
          hold[i]--;
          tx_busy[i] = (hold[i] > 0);
        end else begin
          tx_busy[i] = 1'b0;
        end
      end
    end
  end

  // One block on instance i: start pulse, enc_done after enc_delay cycles,
  // random start/enc_done noise until block_done or the cycle budget runs out.
  task automatic applyStimulus(input int i, input int enc_delay);
    bit seen = 0;
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
    repeat (enc_delay - 1) begin
      @(negedge clk);
      start[i] = ($urandom_range(7, 0) == 0);
    end
    @(negedge clk) begin start[i] = 1'b0; enc_done[i] = 1'b1; end
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (block_done[i]) seen = 1;
      start[i]    = !seen && ($urandom_range(7, 0) == 0);
      enc_done[i] = !seen && ($urandom_range(7, 0) == 0);
    end
    start[i] = 1'b0; enc_done[i] = 1'b0;
    checkOutput("block_done_seen", int'(seen), 1);
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", int'(busy[i]), 0);
    checkOutput("idle_byte_cnt", int'(byte_cnt[i]), DB + 1);
  endtask

  initial begin
    bit seen;
    reset = 1'b0;
    start = '0; enc_done = '0;
    fixed_len[0] = 20; fixed_len[1] = 0;
    // reset held: inputs toggle, outputs must stay quiet
    repeat (8) begin
      @(negedge clk);
      start = 2'($urandom_range(3, 0));
      enc_done = 2'($urandom_range(3, 0));
    end
    checkAllZero(0, "rst_a");
    checkAllZero(1, "rst_b");
    start = '0; enc_done = '0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_busy_a", int'(busy[0]), 0);
    checkOutput("post_rst_busy_b", int'(busy[1]), 0);

    // nominal block with fixed 20-cycle bytes, then randomized blocks
    applyStimulus(0, 10);
    fixed_len[0] = 0;
    for (int b = 0; b < 3; b++) applyStimulus(0, int'($urandom_range(40, 1)));

    // encryption timeout
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < TO_A + 20 && !seen; k++) begin
      @(negedge clk);
      if (err[0]) seen = 1;
    end
    checkOutput("err_seen", int'(seen), 1);
    repeat (2) @(negedge clk);
    checkOutput("err_idle_busy", int'(busy[0]), 0);

    // asynchronous reset during byte 7
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (5) @(negedge clk);
    enc_done[0] = 1'b1;
    @(negedge clk) enc_done[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (tx_cnt[0] >= 8) seen = 1;
    end
    checkOutput("byte7_reached", int'(seen), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 checkAllZero(0, "async_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(0, int'($urandom_range(30, 2)));

    // no-timeout instance waits indefinitely for enc_done, then zero-gap block
    @(negedge clk) start[1] = 1'b1;
    @(negedge clk) start[1] = 1'b0;
    repeat (200) @(negedge clk);
    checkOutput("no_to_enc_en", int'(EnEnc[1]), 1);
    checkOutput("no_to_busy", int'(busy[1]), 1);
    enc_done[1] = 1'b1;
    @(negedge clk) enc_done[1] = 1'b0;
    seen = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (block_done[1]) seen = 1;
    end
    checkOutput("b_block_done_seen", int'(seen), 1);
    applyStimulus(1, int'($urandom_range(30, 1)));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
